// File: rtl/bp_network_serializer_if.sv
// Ready/valid bundle for bp_network_serializer: message-side inputs plus flit-side outputs.
// The master modport is the serializer's view and the slave modport is the surrounding logic's view.
interface bp_network_serializer_if #(
  parameter int unsigned source_data_width_p = 70,
  parameter int unsigned dest_id_width_p     = 2,
  parameter int unsigned flit_width_p        = 36
);
  logic                           v_i;
  logic                           ready_o;
  logic [source_data_width_p-1:0] data_i;
  logic [dest_id_width_p-1:0]     dest_id_i;
  logic                           v_o;
  logic [flit_width_p-1:0]        data_o;
  logic                           ready_i;

  modport master (
    input  v_i, data_i, dest_id_i, ready_i,
    output ready_o, v_o, data_o
  );

  modport slave (
    output v_i, data_i, dest_id_i, ready_i,
    input  ready_o, v_o, data_o
  );
endinterface

// File: rtl/bp_network_serializer.sv
// Splits one wide message into header-tagged flits, lowest slice first.
// Define BP_NETWORK_SERIALIZER_PIPELINE_EN to accept a new message on the last flit's handshake.
module bp_network_serializer #(
  parameter int unsigned num_dest_p          = 4,
  parameter int unsigned num_src_p           = 4,
  parameter int unsigned src_id_p            = 2,
  parameter int unsigned source_data_width_p = 70,
  parameter int unsigned packet_data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_network_serializer_if.master io
);

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 32'd1) ? 32'd1 : 32'($clog2(x));
  endfunction

  localparam int unsigned dest_id_width_lp = safe_clog2(num_dest_p);
  localparam int unsigned src_id_width_lp  = safe_clog2(num_src_p);
  localparam int unsigned num_packets_lp   =
    (source_data_width_p + packet_data_width_p - 1) / packet_data_width_p;
  localparam int unsigned padded_width_lp  = num_packets_lp * packet_data_width_p;
  localparam int unsigned cnt_width_lp     = safe_clog2(num_packets_lp);

  localparam logic [src_id_width_lp-1:0] src_id_lp   = src_id_width_lp'(src_id_p);
  localparam logic [cnt_width_lp-1:0]    last_cnt_lp = cnt_width_lp'(num_packets_lp - 1);

  typedef enum logic {
    eIdle,
    eSend
  } state_e;

  state_e                      state_r;
  logic [padded_width_lp-1:0]  msg_r;
  logic [dest_id_width_lp-1:0] dest_r;
  logic [cnt_width_lp-1:0]     count_r;
  logic                        last_flit;
  logic                        accept;

  assign last_flit = (count_r == last_cnt_lp);

`ifdef BP_NETWORK_SERIALIZER_PIPELINE_EN
  assign io.ready_o = ~reset_i & ((state_r == eIdle)
                                  | ((state_r == eSend) & last_flit & io.ready_i));
`else
  assign io.ready_o = ~reset_i & (state_r == eIdle);
`endif

  assign accept = io.v_i & io.ready_o;

  // The buffer shifts down on each handshake, so the current slice always sits in the low bits.
  assign io.v_o    = (state_r == eSend);
  assign io.data_o = {dest_r, src_id_lp, msg_r[packet_data_width_p-1:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIdle;
      count_r <= '0;
      msg_r   <= '0;
      dest_r  <= '0;
    end else begin
      case (state_r)
        eIdle: begin
          if (accept) begin
            msg_r   <= padded_width_lp'(io.data_i);
            dest_r  <= io.dest_id_i;
            count_r <= '0;
            state_r <= eSend;
          end
        end
        eSend: begin
          if (io.ready_i) begin
            if (last_flit) begin
              // accept can only be high here in the pipelined build
              if (accept) begin
                msg_r   <= padded_width_lp'(io.data_i);
                dest_r  <= io.dest_id_i;
                count_r <= '0;
              end else begin
                state_r <= eIdle;
              end
            end else begin
              count_r <= count_r + 1'b1;
              msg_r   <= msg_r >> packet_data_width_p;
            end
          end
        end
        default: state_r <= eIdle;
      endcase
    end
  end

endmodule

// File: doc/bp_network_serializer.md
# bp_network_serializer

Splits one wide network message into a sequence of fixed-width packets (flits) and sends them on a narrow ready/valid channel toward a per-source reassembly stage at the far end of the network. Each flit carries a routing header {destination id, source id} above one slice of the payload. Slices go lowest-order first, and all slices of one message are sent contiguously. The block sits at a network injection point: one instance per source node, upstream of the deserializer on the receiving side.

## Interface
- `num_dest_p`, "inv": number of destinations. `dest_id_width_lp = BSG_SAFE_CLOG2(num_dest_p)`.
- `num_src_p`, "inv": number of sources. `src_id_width_lp = BSG_SAFE_CLOG2(num_src_p)`.
- `src_id_p`, "inv": this node's source id. It must be less than `num_src_p`.
- `source_data_width_p`, "inv": width of a full message.
- `packet_data_width_p`, "inv": payload bits per flit.
- Derived: `num_packets_lp = ceil(source_data_width_p / packet_data_width_p)`.
- Derived: `flit_width_lp = packet_data_width_p + dest_id_width_lp + src_id_width_lp`.
- `clk_i`  in  1  clock. This is the block's only clock.
- `reset_i`  in  1  synchronous reset, active-high.
- `v_i`  in  1  message valid.
- `ready_o`  out  1  message accepted when `v_i & ready_o`.
- `data_i`  in  `source_data_width_p`  message payload.
- `dest_id_i`  in  `dest_id_width_lp`  message destination.
- `v_o`  out  1  flit valid.
- `data_o`  out  `flit_width_lp`  flit, laid out as {dest_id, src_id, payload slice}, with dest in the MSBs.
- `ready_i`  in  1  downstream accepts the flit when `v_o & ready_i`.

## Operation
- **State machine:** two states.
  - eIdle: `ready_o=1`, `v_o=0`.
  - eSend: `v_o=1`, `ready_o=0`, except as noted under Configuration.
- **Accept:** in eIdle, `v_i & ready_o` captures the message as follows.
  - `data_i` is zero-extended to `num_packets_lp*packet_data_width_p` bits.
  - `dest_id_i` is latched.
  - The slice counter is cleared.
  - The state moves to eSend.
- **Flit k:** `data_o = {dest_r, src_id_p, msg_r[k*packet_data_width_p +: packet_data_width_p]}`.
  - The counter has width `BSG_SAFE_CLOG2(num_packets_lp)`.
  - Padding bits of the last slice are 0.
- **Advance:** each `v_o & ready_i` increments the counter.
  - On the handshake of flit `num_packets_lp-1`, the state returns to eIdle. No wrap-around to slice 0 happens within a message.
- **Backpressure:** while `v_o & ~ready_i`, `data_o` and the counter hold stable.
- **Ignored input:** `v_i` while `ready_o=0` is ignored and has no side effects.
- **Destination id:** not range-checked; it is passed through as given.
- **Single-flit case:** when `num_packets_lp==1`, every message produces exactly one flit.
- **Reset:** `reset_i` in any state, including mid-message, takes effect as follows.
  - The state goes to eIdle and the counter to 0.
  - The partial message is discarded. No further flits of it are sent.
  - Reset values: `v_o=0`, and `ready_o=0` while `reset_i` is high. `ready_o=1` in the first cycle after reset is deasserted.

## Timing
- A message accepted at cycle t drives flit 0 on `v_o` at cycle t+1. The accept-to-first-flit path is registered.
- Flit k appears one cycle after the handshake of flit k-1.
- With `ready_i` held high, a message occupies the output for `num_packets_lp` consecutive cycles.
- Without the pipeline option:
  - `ready_o` rises the cycle after the last flit's handshake.
  - Peak throughput is one message per `num_packets_lp+1` cycles.
- `data_o` and `v_o` are driven from registers only. There is no combinational path from `v_i` or `data_i` to the outputs.

## Configuration
- The macro `BP_NETWORK_SERIALIZER_PIPELINE_EN` selects back-to-back acceptance.
- **Defined:**
  - `ready_o = (state==eIdle) | (state==eSend & last_flit & ready_i)`.
  - A message accepted in the same cycle as the last flit's handshake reloads the buffer, clears the counter and stays in eSend.
  - Its flit 0 appears the next cycle, so there is no bubble and throughput is one message per `num_packets_lp` cycles.
  - This adds a combinational path `ready_i -> ready_o`.
- **Undefined:** `ready_o = (state==eIdle)` only, with no combinational path from `ready_i`.

## Test plan
Configuration for all scenarios: `source_data_width_p=70`, `packet_data_width_p=32`, `num_dest_p=4`, `num_src_p=4`, `src_id_p=2`. This gives 3 flits per message and a 36-bit flit.

- **Basic message:** `ready_i=1`; send `data_i=70'h3F_0000_0002_0000_0001`, `dest=1`. Required response:
  - Flits at t+1..t+3: `36'h6_0000_0001`, `36'h6_0000_0002`, `36'h6_0000_003F`.
  - Upper 26 payload bits of the third flit are 0.
- **Backpressure:** drop `ready_i` for 3 cycles while flit 1 is presented.
  - Required: `data_o` is held at flit 1 for those 3 cycles, then flit 1, flit 2 are sent with no slice repeated or skipped.
- **Back-to-back messages:** two messages with `v_i` held high and `ready_i=1`.
  - Macro defined: 6 flits on consecutive cycles.
  - Macro undefined: one idle cycle between flit 2 and the next flit 0.
  - `ready_o` must never be high while `v_o` shows flit 0 or flit 1.
- **Reset mid-message:** assert `reset_i` one cycle after flit 0 is handshaken.
  - Required: `v_o=0` during reset.
  - The next message starts at slice 0 with its own dest. No stale slices are sent.
- **Busy input ignored:** pulse `v_i` with different data during eSend while `ready_o=0`.
  - Required: the in-flight flits are unchanged and no extra message appears.
- **Single-flit configuration:** `packet_data_width_p=70`.
  - Required: each message yields exactly one flit `{dest, 2'd2, data_i}` at t+1.
